// File: rtl/tremolo_pkg.sv
// Shared definitions for the tremolo LFO blocks: period width, rate limits,
// the FSM state type and a saturating clamp used on widened period values.
package tremolo_pkg;

  localparam int PERIOD_W = 23;

  localparam logic [PERIOD_W-1:0] DEF_PERIOD_MIN     = 23'd480000;
  localparam logic [PERIOD_W-1:0] DEF_PERIOD_MAX     = 23'd8000000;
  localparam logic [PERIOD_W-1:0] DEF_PERIOD_DEFAULT = 23'd4800000;
  localparam logic [PERIOD_W-1:0] DEF_STEP           = 23'd240000;
  localparam logic [PERIOD_W-1:0] DEF_SLEW_STEP      = 23'd4800;

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } rate_state_t;

  // Saturate a one-bit-wider value into [lo, hi].
  function automatic logic [PERIOD_W-1:0] clamp_period(
    input logic [PERIOD_W-1:0] lo,
    input logic [PERIOD_W-1:0] hi,
    input logic [PERIOD_W:0]   v
  );
    logic [PERIOD_W-1:0] r;
    if (v < {1'b0, lo}) begin
      r = lo;
    end else if (v > {1'b0, hi}) begin
      r = hi;
    end else begin
      r = v[PERIOD_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/tremolo_rate_ctrl.sv
// LFO rate controller: button/preset requests update a clamped target period,
// and the live period slews toward it by at most SLEW_STEP per sample strobe.
module tremolo_rate_ctrl
  import tremolo_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] PERIOD_MIN     = DEF_PERIOD_MIN,
  parameter logic [PERIOD_W-1:0] PERIOD_MAX     = DEF_PERIOD_MAX,
  parameter logic [PERIOD_W-1:0] PERIOD_DEFAULT = DEF_PERIOD_DEFAULT,
  parameter logic [PERIOD_W-1:0] STEP           = DEF_STEP,
  parameter logic [PERIOD_W-1:0] SLEW_STEP      = DEF_SLEW_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_strobe,
  input  logic                btn_faster,
  input  logic                btn_slower,
  input  logic                preset_load,
  input  logic [PERIOD_W-1:0] preset_period,
  output logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] target,
  output logic                busy
);

  if (!((PERIOD_MIN <= PERIOD_DEFAULT) && (PERIOD_DEFAULT <= PERIOD_MAX) &&
        (SLEW_STEP > 23'd0))) begin : g_param_check
    $fatal(1, "tremolo_rate_ctrl: illegal period parameters");
  end

  rate_state_t         state_q, state_d;
  logic [PERIOD_W-1:0] target_q, target_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                busy_q, busy_d;

  logic [PERIOD_W:0]   dec_s;
  logic [PERIOD_W:0]   inc_s;
  logic [PERIOD_W-1:0] gap_s;

  // Target request: preset wins, then exactly one of faster/slower.
  always_comb begin
    target_d = target_q;
    dec_s    = {1'b0, target_q} - {1'b0, STEP};
    inc_s    = {1'b0, target_q} + {1'b0, STEP};
    if (preset_load) begin
      target_d = clamp_period(PERIOD_MIN, PERIOD_MAX, {1'b0, preset_period});
    end else if (btn_faster && !btn_slower) begin
      // A set top bit means the subtraction borrowed below zero.
      if (dec_s[PERIOD_W]) begin
        target_d = PERIOD_MIN;
      end else begin
        target_d = clamp_period(PERIOD_MIN, PERIOD_MAX, dec_s);
      end
    end else if (btn_slower && !btn_faster) begin
      target_d = clamp_period(PERIOD_MIN, PERIOD_MAX, inc_s);
    end else begin
      target_d = target_q;
    end
  end

  // Slew FSM: steps the live period toward the registered target on strobes.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    gap_s    = 23'd0;
    case (state_q)
      IDLE: begin
        if (target_q != period_q) begin
          state_d = SLEW;
        end else begin
          state_d = IDLE;
        end
      end
      SLEW: begin
        if (sample_strobe) begin
          if (target_q >= period_q) begin
            gap_s = target_q - period_q;
          end else begin
            gap_s = period_q - target_q;
          end
          if (gap_s <= SLEW_STEP) begin
            period_d = target_q;
            state_d  = IDLE;
          end else if (target_q > period_q) begin
            period_d = period_q + SLEW_STEP;
          end else begin
            period_d = period_q - SLEW_STEP;
          end
        end else begin
          period_d = period_q;
        end
      end
      default: begin
        state_d  = IDLE;
        period_d = period_q;
      end
    endcase
    busy_d = (state_d == SLEW);
  end

  // State, target, live period and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= PERIOD_DEFAULT;
      period_q <= PERIOD_DEFAULT;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      period_q <= period_d;
      busy_q   <= busy_d;
    end
  end

  assign period = period_q;
  assign target = target_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_tremolo_rate_ctrl.sv
// Randomized and directed bench for tremolo_rate_ctrl against an integer
// behavioural model of target clamping and per-strobe rate slewing.
module tb_tremolo_rate_ctrl;

  localparam int P_MIN  = 480000;
  localparam int P_MAX  = 8000000;
  localparam int P_DEF  = 4800000;
  localparam int P_STEP = 240000;
  localparam int P_SLEW = 4800;

  logic        clk;
  logic        rst_n;
  logic        sample_strobe;
  logic        btn_faster;
  logic        btn_slower;
  logic        preset_load;
  logic [22:0] preset_period;
  logic [22:0] period;
  logic [22:0] target;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  int m_tgt;
  int m_per;
  bit m_slewing;

  tremolo_rate_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .btn_faster    (btn_faster),
    .btn_slower    (btn_slower),
    .preset_load   (preset_load),
    .preset_period (preset_period),
    .period        (period),
    .target        (target),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp_int(input int v);
    if (v < P_MIN) return P_MIN;
    if (v > P_MAX) return P_MAX;
    return v;
  endfunction

  // Advance the model by one clock using this cycle's inputs.
  task automatic model_tick(input bit s, input bit f, input bit sl,
                            input bit p, input int pv);
    int  d;
    int  nt;
    bit  was_slewing;
    was_slewing = m_slewing;
    if (was_slewing && s) begin
      d = m_tgt - m_per;
      if (d <= P_SLEW && d >= -P_SLEW) begin
        m_per     = m_tgt;
        m_slewing = 1'b0;
      end else begin
        m_per = m_per + ((d > 0) ? P_SLEW : -P_SLEW);
      end
    end else if (!was_slewing) begin
      m_slewing = (m_tgt != m_per);
    end
    nt = m_tgt;
    if (p) nt = clamp_int(pv);
    else if (f && !sl) nt = clamp_int(m_tgt - P_STEP);
    else if (sl && !f) nt = clamp_int(m_tgt + P_STEP);
    m_tgt = nt;
  endtask

  task automatic compare_all(input string ctx);
    check_val({ctx, ".period"}, int'(period), m_per);
    check_val({ctx, ".target"}, int'(target), m_tgt);
    check_val({ctx, ".busy"}, int'(busy), int'(m_slewing));
    check_val({ctx, ".in_range"}, int'(period >= 23'd480000 && period <= 23'd8000000), 1);
  endtask

  task automatic cyc(input bit s, input bit f, input bit sl,
                     input bit p, input int pv);
    sample_strobe = s;
    btn_faster    = f;
    btn_slower    = sl;
    preset_load   = p;
    preset_period = pv[22:0];
    @(posedge clk);
    model_tick(s, f, sl, p, pv);
    #1;
    compare_all("cyc");
    sample_strobe = 1'b0;
    btn_faster    = 1'b0;
    btn_slower    = 1'b0;
    preset_load   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Strobe every other cycle until n strobes delivered.
  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  task automatic async_reset(input string ctx);
    #3;
    rst_n = 1'b0;
    #1;
    m_tgt     = P_DEF;
    m_per     = P_DEF;
    m_slewing = 1'b0;
    check_val({ctx, ".rst_period"}, int'(period), P_DEF);
    check_val({ctx, ".rst_target"}, int'(target), P_DEF);
    check_val({ctx, ".rst_busy"}, int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    sample_strobe = 1'b0;
    btn_faster    = 1'b0;
    btn_slower    = 1'b0;
    preset_load   = 1'b0;
    preset_period = 23'd0;
    m_tgt         = P_DEF;
    m_per         = P_DEF;
    m_slewing     = 1'b0;
    @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;

    // Faster pulse, then 50 strobes down to 4560000.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    check_val("faster.target", int'(target), 4560000);
    idle_cycles(1);
    strobes(50);
    check_val("faster.landed", int'(period), 4560000);
    idle_cycles(2);
    check_val("faster.busy_low", int'(busy), 0);

    // Saturate low, then preset overflow saturates high.
    for (int i = 0; i < 25; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    check_val("sat.min", int'(target), P_MIN);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h7FFFFF);
    check_val("preset.max", int'(target), P_MAX);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
    check_val("sat.max", int'(target), P_MAX);

    // Both buttons: no change; preset beats faster.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
    check_val("both.nochange", int'(target), P_MAX);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1000000);
    check_val("preset.prio", int'(target), 1000000);

    // Reset mid-slew.
    strobes(5);
    async_reset("midslew");
    idle_cycles(3);

    // Mid-slew reversal.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle_cycles(1);
    strobes(10);
    check_val("rev.period", int'(period), 4848000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    check_val("rev.target", int'(target), P_DEF);
    strobes(10);
    idle_cycles(1);
    check_val("rev.period_back", int'(period), P_DEF);
    check_val("rev.busy_low", int'(busy), 0);

    // Strobe coinciding with the button pulse, then proximity landing.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, P_DEF + 3000);
    idle_cycles(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_val("prox.landed", int'(period), P_DEF + 3000);

    // No strobes: period holds with busy high.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle_cycles(200);
    check_val("hold.busy", int'(busy), 1);
    check_val("hold.period", int'(period), P_DEF + 3000);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      bit s, f, sl, p;
      int pv;
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 39) == 0);
      sl = ($urandom_range(0, 39) == 0);
      p  = ($urandom_range(0, 149) == 0);
      pv = int'($urandom & 32'h007FFFFF);
      if ($urandom_range(0, 2999) == 0) async_reset("rand");
      else cyc(s, f, sl, p, pv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
